cmpl_mul_pipe: RTL
==================

// Module: cmpl_mul_pipe
// PURPOSE
//  Parametrised pipelined complex multiplier for the FFT butterfly and twiddle
//  path. Computes a*b or a*conj(b) at full precision, then scales, rounds and
//  saturates the result to a configurable output width.
//  Adds valid/ready flow control with a whole-pipeline stall, so it can sit
//  between streaming FFT stages without an external FIFO.
// PARAMETERS
//  IN_W     18  width of each signed input component (re/im of a and b)
//  OUT_W    18  width of each signed output component
//  SHIFT    17  arithmetic right shift applied to the full product; 0 = none
//  LAT       3  total latency in cycles from accept to out_valid; legal 2..8
// PORTS
//  clock        in   1          rising-edge clock
//  reset        in   1          synchronous, active-high reset
//  in_valid     in   1          input beat valid
//  in_ready     out  1          block can accept a beat this cycle
//  conj_b       in   1          1: multiply by conj(b); sampled with the beat
//  dataa_real   in   IN_W       a real, signed
//  dataa_imag   in   IN_W       a imag, signed
//  datab_real   in   IN_W       b real, signed
//  datab_imag   in   IN_W       b imag, signed
//  out_valid    out  1          result valid
//  out_ready    in   1          downstream accepts result
//  result_real  out  OUT_W      scaled, rounded, saturated real part
//  result_imag  out  OUT_W      scaled, rounded, saturated imag part
//  result_ovf   out  1          1: this beat saturated in real or imag part
// BEHAVIOUR
//  - Reset: all valid bits, result_real/imag, result_ovf = 0; in_ready = 1 in the
//    cycle after reset deasserts. Reset mid-operation discards in-flight beats.
//  - Global enable en = !out_valid | out_ready; in_ready = en (combinational).
//    Beat accepted when in_valid & in_ready. All stages advance only when en=1.
//  - Stall: out_valid & !out_ready freezes every stage; outputs held stable.
//  - Throughput 1 beat/cycle when out_ready stays high; no bubbles inserted.
//  - Latency exactly LAT enabled cycles. Stage 1 registers products; stage 2
//    forms sums; final stage rounds/saturates; extra LAT-3 stages are delay.
//    LAT=2 merges sum and round/saturate into one stage.
//  - Arithmetic: bi' = conj_b ? -bi : bi, computed at IN_W+1 bits
//    (so -(-2^(IN_W-1)) is exact). re = ar*br - ai*bi', im = ar*bi' + ai*br,
//    full width P = 2*IN_W+2, no intermediate truncation.
//  - Round: if SHIFT>0 add 2^(SHIFT-1) then arithmetic shift by SHIFT
//    (round-half-up toward +inf).
//  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; result_ovf=1 if either part
//    clipped. Unused valid/ovf bits travel with the data.
//  - Bubble (in_valid=0 while en=1) propagates as out_valid=0; data don't-care.
// CONFIGURATION
//  CMUL_OVF_CNT_EN defined: adds port ovf_cnt  out  16  saturating count of
//    beats accepted downstream (out_valid & out_ready) with result_ovf=1;
//    sticks at 16'hFFFF; cleared only by reset.
//  Not defined: port and counter absent; result_ovf still present.
// TESTING
//  1 SHIFT=0, OUT_W=38: a=1+j2, b=3+j4, conj_b=0 -> -5+j10 after exactly LAT cycles.
//  2 Same, conj_b=1 -> 11+j2; ovf=0.
//  3 SHIFT=17, OUT_W=18: a=-131072, b=-131072 (imag 0) -> +131072 clips to
//    131071, result_ovf=1; with CMUL_OVF_CNT_EN, ovf_cnt=1 after handshake.
//  4 Rounding, SHIFT=1: a=3, b=1 -> 2; a=-3, b=1 -> -1.
//  5 Stream 10 beats, out_ready low cycles 4-8: in_ready low same cycles,
//    outputs frozen; all 10 results in order, none lost or duplicated.
//  6 Assert reset with 2 beats in flight -> next cycle out_valid=0, result=0,
//    result_ovf=0; no stale beat emerges afterwards.

Source files
------------

// File: rtl/cmpl_mul_pipe.sv
// Pipelined complex multiplier (a*b or a*conj(b)) with rounding, saturation and a global valid/ready stall.
// Optional feature macro CMUL_OVF_CNT_EN adds o_ovf_cnt, a sticky count of delivered saturated beats.
module cmpl_mul_pipe #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 18,
  parameter int SHIFT = 17,
  parameter int LAT   = 3
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_conj_b,
  input  logic [IN_W-1:0]  i_dataa_real,
  input  logic [IN_W-1:0]  i_dataa_imag,
  input  logic [IN_W-1:0]  i_datab_real,
  input  logic [IN_W-1:0]  i_datab_imag,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [OUT_W-1:0] o_result_real,
  output logic [OUT_W-1:0] o_result_imag,
  output logic             o_result_ovf
`ifdef CMUL_OVF_CNT_EN
  ,
  output logic [15:0]      o_ovf_cnt
`endif
);

  localparam int P  = 2 * IN_W + 2;
  localparam int W  = ((OUT_W > P) ? OUT_W : P) + 1;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int ND = (LAT > 3) ? LAT - 3 : 0;

  localparam logic signed [W-1:0] RND  = (SHIFT > 0) ? (W'(1) << RS) : W'(0);
  localparam logic signed [W-1:0] MAXV = (W'(1) << (OUT_W - 1)) - W'(1);
  localparam logic signed [W-1:0] MINV = ~MAXV;

  // Returns {clipped, value}; the extra headroom bit keeps the rounding add from wrapping.
  function automatic logic [OUT_W:0] roundSat(input logic signed [P-1:0] v);
    logic signed [W-1:0] ext;
    logic signed [W-1:0] rnd;
    ext = {{(W-P){v[P-1]}}, v};
    rnd = (ext + RND) >>> SHIFT;
    if (rnd > MAXV)
      return {1'b1, MAXV[OUT_W-1:0]};
    else if (rnd < MINV)
      return {1'b1, MINV[OUT_W-1:0]};
    else
      return {1'b0, rnd[OUT_W-1:0]};
  endfunction

  logic                w_en;
  logic signed [IN_W:0] w_bi_n;
  logic signed [IN_W:0] w_bi_c;
  logic signed [P-1:0] w_ar;
  logic signed [P-1:0] w_ai;
  logic signed [P-1:0] w_br;
  logic signed [P-1:0] w_bic;

  assign w_en       = ~o_out_valid | i_out_ready;
  assign o_in_ready = w_en;

  // One guard bit on b imag so negating the most negative value stays exact.
  assign w_bi_n = {i_datab_imag[IN_W-1], i_datab_imag};
  assign w_bi_c = i_conj_b ? -w_bi_n : w_bi_n;
  assign w_ar   = {{(P-IN_W){i_dataa_real[IN_W-1]}}, i_dataa_real};
  assign w_ai   = {{(P-IN_W){i_dataa_imag[IN_W-1]}}, i_dataa_imag};
  assign w_br   = {{(P-IN_W){i_datab_real[IN_W-1]}}, i_datab_real};
  assign w_bic  = {{(P-IN_W-1){w_bi_c[IN_W]}}, w_bi_c};

  logic                r_valid1;
  logic signed [P-1:0] r_prr;
  logic signed [P-1:0] r_pii;
  logic signed [P-1:0] r_pri;
  logic signed [P-1:0] r_pir;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid1 <= 1'b0;
      r_prr    <= '0;
      r_pii    <= '0;
      r_pri    <= '0;
      r_pir    <= '0;
    end else if (w_en) begin
      r_valid1 <= i_in_valid;
      r_prr    <= w_ar * w_br;
      r_pii    <= w_ai * w_bic;
      r_pri    <= w_ar * w_bic;
      r_pir    <= w_ai * w_br;
    end
  end

  logic signed [P-1:0] w_sum_re;
  logic signed [P-1:0] w_sum_im;
  logic signed [P-1:0] w_pre_re;
  logic signed [P-1:0] w_pre_im;
  logic                w_pre_v;

  assign w_sum_re = r_prr - r_pii;
  assign w_sum_im = r_pri + r_pir;

  generate
    if (LAT == 2) begin : g_merge
      assign w_pre_re = w_sum_re;
      assign w_pre_im = w_sum_im;
      assign w_pre_v  = r_valid1;
    end else begin : g_sum
      logic signed [P-1:0] r_sum_re;
      logic signed [P-1:0] r_sum_im;
      logic                r_valid2;

      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          r_valid2 <= 1'b0;
          r_sum_re <= '0;
          r_sum_im <= '0;
        end else if (w_en) begin
          r_valid2 <= r_valid1;
          r_sum_re <= w_sum_re;
          r_sum_im <= w_sum_im;
        end
      end

      assign w_pre_re = r_sum_re;
      assign w_pre_im = r_sum_im;
      assign w_pre_v  = r_valid2;
    end
  endgenerate

  logic [OUT_W:0] w_rs_re;
  logic [OUT_W:0] w_rs_im;

  assign w_rs_re = roundSat(w_pre_re);
  assign w_rs_im = roundSat(w_pre_im);

  // Entry 0 is the round/saturate register; higher entries are pure delay.
  logic             r_pipe_v   [ND+1];
  logic             r_pipe_ovf [ND+1];
  logic [OUT_W-1:0] r_pipe_re  [ND+1];
  logic [OUT_W-1:0] r_pipe_im  [ND+1];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k <= ND; k++) begin
        r_pipe_v[k]   <= 1'b0;
        r_pipe_ovf[k] <= 1'b0;
        r_pipe_re[k]  <= '0;
        r_pipe_im[k]  <= '0;
      end
    end else if (w_en) begin
      r_pipe_v[0]   <= w_pre_v;
      r_pipe_ovf[0] <= w_rs_re[OUT_W] | w_rs_im[OUT_W];
      r_pipe_re[0]  <= w_rs_re[OUT_W-1:0];
      r_pipe_im[0]  <= w_rs_im[OUT_W-1:0];
      for (int k = 1; k <= ND; k++) begin
        r_pipe_v[k]   <= r_pipe_v[k-1];
        r_pipe_ovf[k] <= r_pipe_ovf[k-1];
        r_pipe_re[k]  <= r_pipe_re[k-1];
        r_pipe_im[k]  <= r_pipe_im[k-1];
      end
    end
  end

  assign o_out_valid   = r_pipe_v[ND];
  assign o_result_ovf  = r_pipe_ovf[ND];
  assign o_result_real = r_pipe_re[ND];
  assign o_result_imag = r_pipe_im[ND];

`ifdef CMUL_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_ovf_cnt <= '0;
    else if (o_out_valid && i_out_ready && o_result_ovf && (r_ovf_cnt != 16'hFFFF))
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
  end

  assign o_ovf_cnt = r_ovf_cnt;
`else
  // Without the counter, saturation is reported only per beat on o_result_ovf.
`endif

endmodule
